// File: rtl/fast2slow_pulse_tx_pkg.sv
// Shared definitions for the fast-to-slow toggle/ack pulse transmitter and its synchronizer.
package fast2slow_pulse_tx_pkg;

  typedef enum logic {
    ST_IDLE     = 1'b0,
    ST_WAIT_ACK = 1'b1
  } state_t;

  localparam int DEF_SYNC_STAGES = 2;
  localparam int DEF_CNT_W       = 4;

endpackage

// File: rtl/fast2slow_pulse_tx_cdc_bit_sync.sv
// Single-bit multi-flop synchronizer with synchronous reset; output lags input by STAGES edges.
module cdc_bit_sync
  import fast2slow_pulse_tx_pkg::*;
#(
  parameter int STAGES = DEF_SYNC_STAGES
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] chain;

  always_ff @(posedge clk) begin
    if (reset) chain <= '0;
    else       chain <= {chain[STAGES-2:0], d};
  end

  assign q = chain[STAGES-1];

endmodule

// File: rtl/fast2slow_pulse_tx.sv
// Fast-side pulse transmitter: rising edges of in become req toggles, one in flight at a time.
// Zero-latency dispatch when idle; events arriving while busy are counted (saturating, sticky overflow).
module fast2slow_pulse_tx
  import fast2slow_pulse_tx_pkg::*;
#(
  parameter int SYNC_STAGES = DEF_SYNC_STAGES,
  parameter int CNT_W       = DEF_CNT_W
) (
  input  logic             clk1,
  input  logic             reset,
  input  logic             in,
  input  logic             ack_tgl,
  output logic             req_tgl,
  output logic             busy,
  output logic [CNT_W-1:0] pending,
  output logic             ack_pulse,
  output logic             overflow
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  state_t           state, state_n;
  logic             in_d;
  logic             evt;
  logic             ack_s;
  logic             req_n, busy_n, ack_pulse_n, overflow_n;
  logic [CNT_W-1:0] pending_n;

  cdc_bit_sync #(.STAGES(SYNC_STAGES)) u_ack_sync (
    .clk   (clk1),
    .reset (reset),
    .d     (ack_tgl),
    .q     (ack_s)
  );

  assign evt = in & ~in_d;

  always_ff @(posedge clk1) begin
    if (reset) begin
      state     <= ST_IDLE;
      in_d      <= 1'b0;
      req_tgl   <= 1'b0;
      busy      <= 1'b0;
      pending   <= '0;
      ack_pulse <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      state     <= state_n;
      in_d      <= in;
      req_tgl   <= req_n;
      busy      <= busy_n;
      pending   <= pending_n;
      ack_pulse <= ack_pulse_n;
      overflow  <= overflow_n;
    end
  end

  always_comb begin
    state_n     = state;
    req_n       = req_tgl;
    busy_n      = busy;
    pending_n   = pending;
    ack_pulse_n = 1'b0;
    overflow_n  = overflow;
    case (state)
      ST_IDLE: begin
        if (evt || (pending != '0)) begin
          state_n = ST_WAIT_ACK;
          req_n   = ~req_tgl;
          busy_n  = 1'b1;
          // Queued events go first; a simultaneous new event takes the freed slot.
          if (pending != '0) pending_n = pending - CNT_ONE + CNT_W'(evt);
        end
      end
      ST_WAIT_ACK: begin
        if (ack_s == req_tgl) begin
          state_n     = ST_IDLE;
          busy_n      = 1'b0;
          ack_pulse_n = 1'b1;
        end
        if (evt) begin
          if (pending == CNT_MAX) overflow_n = 1'b1;
          else                    pending_n  = pending + CNT_ONE;
        end
      end
    endcase
  end

endmodule

// File: tb/tb_fast2slow_pulse_tx.sv
// Bench for fast2slow_pulse_tx with a two-flop clk2 echo receiver and a toggle scoreboard.
module tb_fast2slow_pulse_tx;

  localparam int CNT_W = 4;
  localparam int QMAX  = (1 << CNT_W) - 1;

  logic             clk1 = 1'b0;
  logic             clk2 = 1'b0;
  logic             reset = 1'b1;
  logic             in_r = 1'b0;
  logic             ack_tgl;
  logic             req_tgl, busy, ack_pulse, overflow;
  logic [CNT_W-1:0] pending;

  logic rx_s1 = 1'b0, rx_s2 = 1'b0;
  logic rx_hold = 1'b0, rx_reset = 1'b0;

  int   vectors = 0, miscompares = 0;
  int   tog_cnt = 0, ack_cnt = 0;
  logic exp_q[$];
  logic exp_req = 1'b0;

  fast2slow_pulse_tx #(.SYNC_STAGES(2), .CNT_W(CNT_W)) dut (
    .clk1      (clk1),
    .reset     (reset),
    .in        (in_r),
    .ack_tgl   (ack_tgl),
    .req_tgl   (req_tgl),
    .busy      (busy),
    .pending   (pending),
    .ack_pulse (ack_pulse),
    .overflow  (overflow)
  );

  always #5 clk1 = ~clk1;
  initial begin
    #2 clk2 = 1'b1;
    forever #10 clk2 = ~clk2;
  end

  // Slow-domain receiver: sync req_tgl in two clk2 flops and echo it back.
  always @(posedge clk2) begin
    if (rx_reset) begin
      rx_s1 <= 1'b0;
      rx_s2 <= 1'b0;
    end else if (!rx_hold) begin
      rx_s1 <= req_tgl;
      rx_s2 <= rx_s1;
    end
  end
  assign ack_tgl = rx_s2;

  task automatic check(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every req toggle must match the next scoreboard entry.
  initial begin
    logic prev_req = 1'b0;
    logic prev_ack = 1'b0;
    logic e;
    forever begin
      @(posedge clk1);
      #1;
      if (reset) begin
        prev_req = req_tgl;
        prev_ack = 1'b0;
        tog_cnt  = 0;
        ack_cnt  = 0;
        continue;
      end
      if (req_tgl !== prev_req) begin
        tog_cnt++;
        check("toggle_expected", int'(exp_q.size() != 0), 1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          check("req_tgl_value", int'(req_tgl), int'(e));
        end
        check("busy_on_toggle", int'(busy), 1);
      end
      if (ack_pulse === 1'b1) begin
        ack_cnt++;
        check("ack_pulse_single", int'(prev_ack), 0);
      end
      prev_ack = ack_pulse;
      prev_req = req_tgl;
    end
  end

  // Reference model: an event is lost only if it arrives while the queue is full.
  task automatic post_event();
    if (exp_q.size() >= QMAX) return;
    exp_req = ~exp_req;
    exp_q.push_back(exp_req);
  endtask

  task automatic pulse(input int width, input int gap);
    in_r = 1'b1;
    post_event();
    repeat (width) @(negedge clk1);
    in_r = 1'b0;
    repeat (gap) @(negedge clk1);
  endtask

  task automatic drain(input string name);
    bit done = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      if (busy === 1'b0 && pending === '0 && exp_q.size() == 0) begin
        done = 1'b1;
        break;
      end
      @(negedge clk1);
    end
    check({name, "_drain"}, int'(done), 1);
    check({name, "_acks_eq_toggles"}, ack_cnt, tog_cnt);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit found;
    @(negedge clk1);
    reset = 1'b0;
    check("rst_req", int'(req_tgl), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_pending", int'(pending), 0);
    check("rst_ack_pulse", int'(ack_pulse), 0);
    check("rst_overflow", int'(overflow), 0);
    repeat (2) @(negedge clk1);

    // Level held for 3 cycles: single event, zero-latency dispatch.
    in_r = 1'b1;
    post_event();
    @(posedge clk1); #1;
    check("t1_req_latency", int'(req_tgl), 1);
    check("t1_busy", int'(busy), 1);
    repeat (3) @(negedge clk1);
    in_r = 1'b0;
    drain("t1");
    check("t1_toggles", tog_cnt, 1);
    check("t1_pending", int'(pending), 0);

    // Three pulses while the first is in flight.
    rx_hold = 1'b1;
    for (int i = 0; i < 3; i++) pulse(1, 1);
    check("t2_pending", int'(pending), 2);
    rx_hold = 1'b0;
    drain("t2");
    check("t2_toggles", tog_cnt, 4);

    // Saturation: 17 pulses against one outstanding request.
    rx_hold = 1'b1;
    for (int i = 0; i < 17; i++) pulse(1, 1);
    check("t3_pending_sat", int'(pending), QMAX);
    check("t3_overflow", int'(overflow), 1);
    rx_hold = 1'b0;
    drain("t3");
    check("t3_toggles", tog_cnt, 20);
    check("t3_overflow_sticky", int'(overflow), 1);

    // Event on the same edge as ack completion.
    pulse(1, 1);
    found = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (ack_tgl === req_tgl) begin
        found = 1'b1;
        break;
      end
      @(negedge clk1);
    end
    check("t4_ack_seen", int'(found), 1);
    @(negedge clk1);
    in_r = 1'b1;
    post_event();
    @(posedge clk1); #1;
    check("t4_pending_inc", int'(pending), 1);
    check("t4_busy_idle", int'(busy), 0);
    check("t4_ack_pulse", int'(ack_pulse), 1);
    @(posedge clk1); #1;
    check("t4_pending_sent", int'(pending), 0);
    check("t4_busy_again", int'(busy), 1);
    @(negedge clk1);
    in_r = 1'b0;
    drain("t4");

    // Randomized bursts, small enough that nothing is dropped.
    for (int b = 0; b < 6; b++) begin
      int n;
      n = int'($urandom_range(1, 12));
      for (int i = 0; i < n; i++)
        pulse(int'($urandom_range(1, 3)), int'($urandom_range(1, 5)));
      drain("rnd");
    end

    // Reset while busy with five queued events.
    rx_hold = 1'b1;
    for (int i = 0; i < 6; i++) pulse(1, 1);
    check("t5_pending", int'(pending), 5);
    check("t5_busy", int'(busy), 1);
    reset    = 1'b1;
    rx_reset = 1'b1;
    rx_hold  = 1'b0;
    exp_q.delete();
    exp_req = 1'b0;
    repeat (3) @(negedge clk1);
    reset    = 1'b0;
    rx_reset = 1'b0;
    check("t5_req", int'(req_tgl), 0);
    check("t5_busy_clr", int'(busy), 0);
    check("t5_pending_clr", int'(pending), 0);
    check("t5_overflow_clr", int'(overflow), 0);
    @(negedge clk1);
    in_r = 1'b1;
    post_event();
    @(posedge clk1); #1;
    check("t5_req_after", int'(req_tgl), 1);
    @(negedge clk1);
    in_r = 1'b0;
    drain("t5");
    check("t5_toggles", tog_cnt, 1);

    repeat (5) @(negedge clk1);
    check("final_queue_empty", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
